// File: rtl/dual_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decode pop side and the two slot outputs.
// master = fetch/decode environment, slave = dual_fetch_queue.
interface dual_fetch_queue_if #(
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush;
  logic [1:0]       in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr0;
  logic [31:0]      in_instr1;
  logic             in_ready;
  logic [1:0]       pop_cnt;

  logic             validF1;
  logic [31:0]      PCF1;
  logic [31:0]      InstrF1;
  logic [31:0]      PCPlus4F1;
  logic [31:0]      PCPlus8F1;
  logic             validF2;
  logic [31:0]      PCF2;
  logic [31:0]      InstrF2;
  logic [31:0]      PCPlus4F2;
  logic [31:0]      PCPlus8F2;
  logic [PTR_W:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr0, in_instr1, pop_cnt,
    input  in_ready, validF1, PCF1, InstrF1, PCPlus4F1, PCPlus8F1,
    input  validF2, PCF2, InstrF2, PCPlus4F2, PCPlus8F2, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr0, in_instr1, pop_cnt,
    output in_ready, validF1, PCF1, InstrF1, PCPlus4F1, PCPlus8F1,
    output validF2, PCF2, InstrF2, PCPlus4F2, PCPlus8F2, count
  );
endinterface

// File: rtl/dual_fetch_queue.sv
// 2-wide circular fetch queue; slot outputs are combinational from the two oldest entries.
// Optional FETCH_QUEUE_BYPASS_EN forwards a push into an empty queue to the slots the same cycle.
module dual_fetch_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  dual_fetch_queue_if.slave fq
);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic             ready;
  logic             bypass;
  logic [1:0]       push_n;
  logic [1:0]       pop_req;
  logic [1:0]       avail;
  logic [1:0]       pop_n;

  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  // Readiness ignores this cycle's pop so fetch never depends on decode timing.
  assign ready       = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign fq.in_ready = ready;
  assign fq.count    = count_q;

  always_comb begin
    push_n = 2'd0;
    if (ready && !fq.flush) begin
      case (fq.in_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && (push_n != 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign pop_req = (fq.pop_cnt == 2'd3) ? 2'd2 : fq.pop_cnt;

  always_comb begin
    avail = (count_q >= (PTR_W+1)'(2)) ? 2'd2 : count_q[1:0];
    if (bypass) begin
      avail = push_n;
    end
    pop_n = (pop_req < avail) ? pop_req : avail;
  end

  // Bypassed entries that decode consumes are still written but lie behind the new head.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    count_d  = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
    if (fq.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_n != 2'd0) begin
      pc_q[wr_ptr_q]    <= fq.in_pc;
      instr_q[wr_ptr_q] <= fq.in_instr0;
      if (push_n == 2'd2) begin
        pc_q[wr_ptr_p1]    <= fq.in_pc + 32'd4;
        instr_q[wr_ptr_p1] <= fq.in_instr1;
      end
    end
  end

  logic        v1, v2;
  logic [31:0] pc1, pc2, ins1, ins2;

  always_comb begin
    v1   = (count_q >= (PTR_W+1)'(1));
    v2   = (count_q >= (PTR_W+1)'(2));
    pc1  = pc_q[rd_ptr_q];
    ins1 = instr_q[rd_ptr_q];
    pc2  = pc_q[rd_ptr_p1];
    ins2 = instr_q[rd_ptr_p1];
    if (bypass) begin
      v1   = 1'b1;
      v2   = (push_n == 2'd2);
      pc1  = fq.in_pc;
      ins1 = fq.in_instr0;
      pc2  = fq.in_pc + 32'd4;
      ins2 = fq.in_instr1;
    end
  end

  // Empty slots present as all-zero bubbles.
  always_comb begin
    fq.validF1   = v1;
    fq.PCF1      = v1 ? pc1 : 32'd0;
    fq.InstrF1   = v1 ? ins1 : 32'd0;
    fq.PCPlus4F1 = v1 ? pc1 + 32'd4 : 32'd0;
    fq.PCPlus8F1 = v1 ? pc1 + 32'd8 : 32'd0;
    fq.validF2   = v2;
    fq.PCF2      = v2 ? pc2 : 32'd0;
    fq.InstrF2   = v2 ? ins2 : 32'd0;
    fq.PCPlus4F2 = v2 ? pc2 + 32'd4 : 32'd0;
    fq.PCPlus8F2 = v2 ? pc2 + 32'd8 : 32'd0;
  end

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed vector bench for dual_fetch_queue (DEPTH=8); honours FETCH_QUEUE_BYPASS_EN if defined.
module tb_dual_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dual_fetch_queue_if #(.DEPTH(8)) bus ();

  dual_fetch_queue #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (bus)
  );

  typedef struct {
    string       name;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  pop;
    int          e_count;
    logic        e_ready;
    logic        e_v1;
    logic [31:0] e_pc1;
    logic [31:0] e_ins1;
    logic        e_v2;
    logic [31:0] e_pc2;
    logic [31:0] e_ins2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic fl, logic [1:0] iv, logic [31:0] pc,
                              logic [31:0] a, logic [31:0] b, logic [1:0] pop, int c,
                              logic rdy, logic v1, logic [31:0] p1, logic [31:0] n1,
                              logic v2, logic [31:0] p2, logic [31:0] n2);
    vec_t v;
    v.name = nm; v.flush = fl; v.in_valid = iv; v.in_pc = pc; v.i0 = a; v.i1 = b; v.pop = pop;
    v.e_count = c; v.e_ready = rdy; v.e_v1 = v1; v.e_pc1 = p1; v.e_ins1 = n1;
    v.e_v2 = v2; v.e_pc2 = p2; v.e_ins2 = n2;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.in_valid = 2'b00; bus.in_pc = 32'd0;
    bus.in_instr0 = 32'd0; bus.in_instr1 = 32'd0; bus.pop_cnt = 2'd0;
  endtask

  task automatic check_slots(string nm, int c, logic rdy, logic v1, logic [31:0] p1,
                             logic [31:0] n1, logic v2, logic [31:0] p2, logic [31:0] n2);
    check({nm, ".count"},     32'(bus.count), 32'(c));
    check({nm, ".in_ready"},  32'(bus.in_ready), 32'(rdy));
    check({nm, ".validF1"},   32'(bus.validF1), 32'(v1));
    check({nm, ".PCF1"},      bus.PCF1,      v1 ? p1 : 32'd0);
    check({nm, ".InstrF1"},   bus.InstrF1,   v1 ? n1 : 32'd0);
    check({nm, ".PCPlus4F1"}, bus.PCPlus4F1, v1 ? p1 + 32'd4 : 32'd0);
    check({nm, ".PCPlus8F1"}, bus.PCPlus8F1, v1 ? p1 + 32'd8 : 32'd0);
    check({nm, ".validF2"},   32'(bus.validF2), 32'(v2));
    check({nm, ".PCF2"},      bus.PCF2,      v2 ? p2 : 32'd0);
    check({nm, ".InstrF2"},   bus.InstrF2,   v2 ? n2 : 32'd0);
    check({nm, ".PCPlus4F2"}, bus.PCPlus4F2, v2 ? p2 + 32'd4 : 32'd0);
    check({nm, ".PCPlus8F2"}, bus.PCPlus8F2, v2 ? p2 + 32'd8 : 32'd0);
  endtask

  initial begin
    // name, flush, in_valid, in_pc, i0, i1, pop | count, ready, v1, pc1, ins1, v2, pc2, ins2
    vecs.push_back(mk("push_pair",  0, 2'b11, 32'h100, 32'hA, 32'hB, 0, 2, 1, 1, 32'h100, 32'hA, 1, 32'h104, 32'hB));
    vecs.push_back(mk("pop1",       0, 2'b00, 0, 0, 0, 1,                1, 1, 1, 32'h104, 32'hB, 0, 0, 0));
    vecs.push_back(mk("pop2_clamp", 0, 2'b00, 0, 0, 0, 2,                0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pop_empty",  0, 2'b00, 0, 0, 0, 2,                0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("push_one",   0, 2'b01, 32'h300, 32'hC, 32'hEE, 0, 1, 1, 1, 32'h300, 32'hC, 0, 0, 0));
    vecs.push_back(mk("push_pop",   0, 2'b11, 32'h304, 32'hD, 32'hE, 1, 2, 1, 1, 32'h304, 32'hD, 1, 32'h308, 32'hE));
    vecs.push_back(mk("pop3_as_2",  0, 2'b00, 0, 0, 0, 3,                0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("fill1", 0, 2'b11, 32'h1000, 32'hC0DE1000, 32'hC0DE1004, 0, 2, 1, 1, 32'h1000, 32'hC0DE1000, 1, 32'h1004, 32'hC0DE1004));
    vecs.push_back(mk("fill2", 0, 2'b11, 32'h1008, 32'hC0DE1008, 32'hC0DE100C, 0, 4, 1, 1, 32'h1000, 32'hC0DE1000, 1, 32'h1004, 32'hC0DE1004));
    vecs.push_back(mk("fill3", 0, 2'b11, 32'h1010, 32'hC0DE1010, 32'hC0DE1014, 0, 6, 1, 1, 32'h1000, 32'hC0DE1000, 1, 32'h1004, 32'hC0DE1004));
    vecs.push_back(mk("fill4", 0, 2'b11, 32'h1018, 32'hC0DE1018, 32'hC0DE101C, 0, 8, 0, 1, 32'h1000, 32'hC0DE1000, 1, 32'h1004, 32'hC0DE1004));
    vecs.push_back(mk("push_full", 0, 2'b11, 32'h2000, 32'h2, 32'h3, 0,  8, 0, 1, 32'h1000, 32'hC0DE1000, 1, 32'h1004, 32'hC0DE1004));
    vecs.push_back(mk("pop_full",  0, 2'b00, 0, 0, 0, 2,                  6, 1, 1, 32'h1008, 32'hC0DE1008, 1, 32'h100C, 32'hC0DE100C));
    vecs.push_back(mk("push_wrap", 0, 2'b11, 32'h1020, 32'hC0DE1020, 32'hC0DE1024, 0, 8, 0, 1, 32'h1008, 32'hC0DE1008, 1, 32'h100C, 32'hC0DE100C));
    vecs.push_back(mk("drain1", 0, 2'b00, 0, 0, 0, 2, 6, 1, 1, 32'h1010, 32'hC0DE1010, 1, 32'h1014, 32'hC0DE1014));
    vecs.push_back(mk("drain2", 0, 2'b00, 0, 0, 0, 2, 4, 1, 1, 32'h1018, 32'hC0DE1018, 1, 32'h101C, 32'hC0DE101C));
    vecs.push_back(mk("drain3", 0, 2'b00, 0, 0, 0, 2, 2, 1, 1, 32'h1020, 32'hC0DE1020, 1, 32'h1024, 32'hC0DE1024));
    vecs.push_back(mk("refill1", 0, 2'b11, 32'h3000, 32'hC0DE3000, 32'hC0DE3004, 0, 4, 1, 1, 32'h1020, 32'hC0DE1020, 1, 32'h1024, 32'hC0DE1024));
    vecs.push_back(mk("refill2", 0, 2'b11, 32'h3008, 32'hC0DE3008, 32'hC0DE300C, 0, 6, 1, 1, 32'h1020, 32'hC0DE1020, 1, 32'h1024, 32'hC0DE1024));
    vecs.push_back(mk("refill3", 0, 2'b01, 32'h3010, 32'hC0DE3010, 32'h0, 0,        7, 0, 1, 32'h1020, 32'hC0DE1020, 1, 32'h1024, 32'hC0DE1024));
    vecs.push_back(mk("stall_pop", 0, 2'b11, 32'h4000, 32'h4, 32'h5, 2,            5, 1, 1, 32'h3000, 32'hC0DE3000, 1, 32'h3004, 32'hC0DE3004));
    vecs.push_back(mk("to_six", 0, 2'b01, 32'h3014, 32'hC0DE3014, 32'h0, 0,        6, 1, 1, 32'h3000, 32'hC0DE3000, 1, 32'h3004, 32'hC0DE3004));
    vecs.push_back(mk("flush", 1, 2'b11, 32'h5000, 32'h6, 32'h7, 2,               0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("post_flush", 0, 2'b11, 32'h6000, 32'h60, 32'h64, 0,        2, 1, 1, 32'h6000, 32'h60, 1, 32'h6004, 32'h64));
    vecs.push_back(mk("post_drain", 0, 2'b00, 0, 0, 0, 2,                         0, 1, 0, 0, 0, 0, 0, 0));

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_slots("reset", 0, 1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      bus.flush = vecs[i].flush; bus.in_valid = vecs[i].in_valid; bus.in_pc = vecs[i].in_pc;
      bus.in_instr0 = vecs[i].i0; bus.in_instr1 = vecs[i].i1; bus.pop_cnt = vecs[i].pop;
      @(posedge clk);
      #1 idle();
      #1 check_slots(vecs[i].name, vecs[i].e_count, vecs[i].e_ready, vecs[i].e_v1,
                     vecs[i].e_pc1, vecs[i].e_ins1, vecs[i].e_v2, vecs[i].e_pc2, vecs[i].e_ins2);
    end

    // Empty-queue push with same-cycle pop: forwarded only when bypass is compiled in.
    bus.in_valid = 2'b11; bus.in_pc = 32'h200; bus.in_instr0 = 32'h20; bus.in_instr1 = 32'h24;
    bus.pop_cnt = 2'd1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check_slots("byp_same", 0, 1, 1, 32'h200, 32'h20, 1, 32'h204, 32'h24);
    @(posedge clk);
    #1 idle();
    #1 check_slots("byp_next", 1, 1, 1, 32'h204, 32'h24, 0, 0, 0);
`else
    check_slots("nobyp_same", 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 idle();
    #1 check_slots("nobyp_next", 2, 1, 1, 32'h200, 32'h20, 1, 32'h204, 32'h24);
`endif

    // Reset mid-operation clears like a flush.
    bus.in_valid = 2'b11; bus.in_pc = 32'h700; rst = 1'b1;
    @(posedge clk);
    #1 idle(); rst = 1'b0;
    #1 check_slots("mid_reset", 0, 1, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
